// File: rtl/sdram_request_scheduler.sv
// ---------------------------------------------------------------------------
// sdram_request_scheduler
//   Front end of the SDRAM command FSM. Buffers host read/write requests in a
//   2-entry FIFO and presents the head as rd_enable/wr_enable/req_addr. It
//   watches the FSM state output to pop accepted requests, flag protocol
//   errors, time refreshes and report operation completion.
//
// Ports
//   CLK, RESET        clock, asynchronous active-low reset
//   host_valid/ready  request handshake (push when both high)
//   host_we/addr      request type (1 = write) and address
//   ctrl_state        5-bit state of the SDRAM command FSM
//   rd/wr_enable      request to the FSM for the queue head
//   req_addr          head address (0 when the queue is empty)
//   refresh_cnt       saturating cycles-since-refresh counter
//   refresh_urgent    refresh_cnt >= REFRESH_THRESHOLD
//   op_done/_we       one-cycle completion pulse and its op type
//   queue_count       occupied entries (0..2)
//   proto_err         sticky: FSM accepted a type other than the head
// ---------------------------------------------------------------------------
module sdram_request_scheduler #(
   parameter int ADDR_WIDTH        = 22,
   parameter int REFRESH_WIDTH     = 10,
   parameter int REFRESH_THRESHOLD = 519
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic                     host_valid,
   output logic                     host_ready,
   input  logic                     host_we,
   input  logic [ADDR_WIDTH-1:0]    host_addr,
   input  logic [4:0]               ctrl_state,
   output logic                     rd_enable,
   output logic                     wr_enable,
   output logic [ADDR_WIDTH-1:0]    req_addr,
   output logic [REFRESH_WIDTH-1:0] refresh_cnt,
   output logic                     refresh_urgent,
   output logic                     op_done,
   output logic                     op_done_we,
   output logic [1:0]               queue_count,
   output logic                     proto_err
);

   localparam logic [4:0] ST_IDLE      = 5'b00000;
   localparam logic [4:0] ST_REF_START = 5'b00001;
   localparam logic [4:0] ST_INIT      = 5'b01000;
   localparam logic [4:0] ST_INIT_LAST = 5'b01111;
   localparam logic [4:0] ST_WR_START  = 5'b11000;
   localparam logic [4:0] ST_RD_START  = 5'b10000;

   logic [4:0]               prev_state_q;
   logic [1:0]               cnt_q, cnt_d;
   logic                     we0_q, we0_d, we1_q, we1_d;
   logic [ADDR_WIDTH-1:0]    addr0_q, addr0_d, addr1_q, addr1_d;
   logic [REFRESH_WIDTH-1:0] ref_q, ref_d;
   logic                     done_q, done_d, done_we_q, done_we_d;
   logic                     perr_q, perr_d;

   logic head_valid, push, pop, accept, acc_we, ref_clr, done_evt, slot0;

   // Events are edges of the FSM state, so a state held for many cycles
   // (clock-enabled FSM) fires each event only once.
   assign accept   = (prev_state_q == ST_IDLE) &&
                     ((ctrl_state == ST_WR_START) || (ctrl_state == ST_RD_START));
   assign acc_we   = ctrl_state[3];
   assign ref_clr  = ((prev_state_q == ST_IDLE) && (ctrl_state == ST_REF_START)) ||
                     ((prev_state_q == ST_INIT_LAST) && (ctrl_state == ST_IDLE));
   assign done_evt = prev_state_q[4] && (ctrl_state == ST_IDLE);

   assign head_valid = (cnt_q != 2'd0);
   assign host_ready = (cnt_q != 2'd2);
   assign push       = host_valid && host_ready;
   assign pop        = accept && head_valid;

   // After a pop the surviving entry shifts into slot 0, so the free slot
   // for a simultaneous push is one lower than the current count.
   assign slot0 = pop ? (cnt_q == 2'd1) : (cnt_q == 2'd0);

   always_comb begin
      we0_d   = we0_q;
      we1_d   = we1_q;
      addr0_d = addr0_q;
      addr1_d = addr1_q;
      cnt_d   = cnt_q;
      if (pop) begin
         we0_d   = we1_q;
         addr0_d = addr1_q;
      end
      if (push) begin
         if (slot0) begin
            we0_d   = host_we;
            addr0_d = host_addr;
         end else begin
            we1_d   = host_we;
            addr1_d = host_addr;
         end
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_comb begin
      perr_d = perr_q;
      if (accept && (!head_valid || (acc_we != we0_q)))
         perr_d = 1'b1;

      ref_d = ref_q;
      if (ref_clr)
         ref_d = '0;
      else if (ref_q != {REFRESH_WIDTH{1'b1}})
         ref_d = ref_q + 1'b1;

      done_d    = done_evt;
      done_we_d = done_evt ? prev_state_q[3] : done_we_q;
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         prev_state_q <= ST_INIT;
         cnt_q        <= 2'd0;
         we0_q        <= 1'b0;
         we1_q        <= 1'b0;
         addr0_q      <= '0;
         addr1_q      <= '0;
         ref_q        <= '0;
         done_q       <= 1'b0;
         done_we_q    <= 1'b0;
         perr_q       <= 1'b0;
      end else begin
         prev_state_q <= ctrl_state;
         cnt_q        <= cnt_d;
         we0_q        <= we0_d;
         we1_q        <= we1_d;
         addr0_q      <= addr0_d;
         addr1_q      <= addr1_d;
         ref_q        <= ref_d;
         done_q       <= done_d;
         done_we_q    <= done_we_d;
         perr_q       <= perr_d;
      end
   end

   assign wr_enable      = head_valid && we0_q;
   assign rd_enable      = head_valid && !we0_q;
   assign req_addr       = head_valid ? addr0_q : '0;
   assign refresh_cnt    = ref_q;
   assign refresh_urgent = (ref_q >= REFRESH_WIDTH'(REFRESH_THRESHOLD));
   assign op_done        = done_q;
   assign op_done_we     = done_we_q;
   assign queue_count    = cnt_q;
   assign proto_err      = perr_q;

endmodule

// File: tb/tb_sdram_request_scheduler.sv
// ---------------------------------------------------------------------------
// tb_sdram_request_scheduler
//   Directed-vector bench for sdram_request_scheduler. Inputs change #1 after
//   the rising edge and outputs are sampled in that same window.
// ---------------------------------------------------------------------------
module tb_sdram_request_scheduler;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        host_valid, host_ready, host_we;
   logic [21:0] host_addr;
   logic [4:0]  ctrl_state;
   logic        rd_enable, wr_enable;
   logic [21:0] req_addr;
   logic [9:0]  refresh_cnt;
   logic        refresh_urgent, op_done, op_done_we;
   logic [1:0]  queue_count;
   logic        proto_err;

   int n_run  = 0;
   int n_fail = 0;

   localparam logic [21:0] A_W = 22'h12345;
   localparam logic [21:0] A_A = 22'h0AAAA;
   localparam logic [21:0] A_B = 22'h3BBBB;
   localparam logic [21:0] A_X = 22'h11111;
   localparam logic [21:0] A_C = 22'h2CCCC;
   localparam logic [21:0] A_D = 22'h0DDDD;
   localparam logic [21:0] A_E = 22'h1EEEE;

   sdram_request_scheduler dut (
      .CLK            (CLK),
      .RESET          (RESET),
      .host_valid     (host_valid),
      .host_ready     (host_ready),
      .host_we        (host_we),
      .host_addr      (host_addr),
      .ctrl_state     (ctrl_state),
      .rd_enable      (rd_enable),
      .wr_enable      (wr_enable),
      .req_addr       (req_addr),
      .refresh_cnt    (refresh_cnt),
      .refresh_urgent (refresh_urgent),
      .op_done        (op_done),
      .op_done_we     (op_done_we),
      .queue_count    (queue_count),
      .proto_err      (proto_err)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " count"},   32'(queue_count), 32'd0);
      chk({tag, " ready"},   32'(host_ready), 32'd1);
      chk({tag, " rd_en"},   32'(rd_enable), 32'd0);
      chk({tag, " wr_en"},   32'(wr_enable), 32'd0);
      chk({tag, " addr"},    32'(req_addr), 32'd0);
      chk({tag, " ref"},     32'(refresh_cnt), 32'd0);
      chk({tag, " urgent"},  32'(refresh_urgent), 32'd0);
      chk({tag, " done"},    32'(op_done), 32'd0);
      chk({tag, " done_we"}, 32'(op_done_we), 32'd0);
      chk({tag, " perr"},    32'(proto_err), 32'd0);
   endtask

   initial begin
      RESET = 1'b0; host_valid = 1'b0; host_we = 1'b0; host_addr = '0;
      ctrl_state = 5'b01000;
      #2;
      chk_reset_vals("rst");
      cyc(); cyc();
      RESET = 1'b1;

      // Init: counter runs freely, INIT_LAST->IDLE clears it.
      repeat (50) cyc();
      chk("init ready", 32'(host_ready), 32'd1);
      chk("init en", 32'({rd_enable, wr_enable}), 32'd0);
      chk("init ref50", 32'(refresh_cnt), 32'd50);
      ctrl_state = 5'b01111; cyc();
      ctrl_state = 5'b00000; cyc();
      chk("init ref clr", 32'(refresh_cnt), 32'd0);

      // Single write: push, accept, complete.
      host_valid = 1'b1; host_we = 1'b1; host_addr = A_W; cyc();
      host_valid = 1'b0;
      chk("w1 wr_en", 32'(wr_enable), 32'd1);
      chk("w1 rd_en", 32'(rd_enable), 32'd0);
      chk("w1 addr", 32'(req_addr), 32'(A_W));
      ctrl_state = 5'b11000; cyc();
      chk("w1 acc count", 32'(queue_count), 32'd0);
      chk("w1 acc wr_en", 32'(wr_enable), 32'd0);
      chk("w1 perr", 32'(proto_err), 32'd0);
      ctrl_state = 5'b11011; cyc();
      chk("w1 no done yet", 32'(op_done), 32'd0);
      ctrl_state = 5'b00000; cyc();
      chk("w1 done", 32'(op_done), 32'd1);
      chk("w1 done_we", 32'(op_done_we), 32'd1);
      cyc();
      chk("w1 done pulse", 32'(op_done), 32'd0);
      chk("w1 done_we hold", 32'(op_done_we), 32'd1);

      // Fill the queue: read A, write B.
      host_valid = 1'b1; host_we = 1'b0; host_addr = A_A; cyc();
      host_we = 1'b1; host_addr = A_B; cyc();
      chk("q2 count", 32'(queue_count), 32'd2);
      chk("q2 ready", 32'(host_ready), 32'd0);
      chk("q2 rd_en", 32'(rd_enable), 32'd1);
      chk("q2 addr", 32'(req_addr), 32'(A_A));
      // Accept read while host still offers X: full queue must block it.
      host_addr = A_X; ctrl_state = 5'b10000; cyc();
      host_valid = 1'b0;
      chk("q2 pop count", 32'(queue_count), 32'd1);
      chk("q2 head wr_en", 32'(wr_enable), 32'd1);
      chk("q2 head addr", 32'(req_addr), 32'(A_B));
      chk("q2 ready", 32'(host_ready), 32'd1);
      ctrl_state = 5'b00000; cyc();
      chk("rd done", 32'(op_done), 32'd1);
      chk("rd done_we", 32'(op_done_we), 32'd0);

      // Refresh threshold, clear and saturation.
      ctrl_state = 5'b00001; cyc();
      chk("ref clr", 32'(refresh_cnt), 32'd0);
      ctrl_state = 5'b00000;
      repeat (518) cyc();
      chk("ref 518", 32'(refresh_cnt), 32'd518);
      chk("ref 518 urg", 32'(refresh_urgent), 32'd0);
      cyc();
      chk("ref 519", 32'(refresh_cnt), 32'd519);
      chk("ref 519 urg", 32'(refresh_urgent), 32'd1);
      ctrl_state = 5'b00001; cyc();
      chk("ref clr2", 32'(refresh_cnt), 32'd0);
      chk("ref clr2 urg", 32'(refresh_urgent), 32'd0);
      ctrl_state = 5'b00000;
      repeat (1100) cyc();
      chk("ref sat", 32'(refresh_cnt), 32'd1023);
      chk("ref sat urg", 32'(refresh_urgent), 32'd1);

      // Drain B correctly, then a type mismatch on a read head.
      ctrl_state = 5'b11000; cyc();
      chk("B acc count", 32'(queue_count), 32'd0);
      chk("B acc perr", 32'(proto_err), 32'd0);
      ctrl_state = 5'b00000; cyc();
      host_valid = 1'b1; host_we = 1'b0; host_addr = A_C; cyc();
      host_valid = 1'b0;
      chk("C rd_en", 32'(rd_enable), 32'd1);
      ctrl_state = 5'b11000; cyc();
      chk("mis perr", 32'(proto_err), 32'd1);
      chk("mis count", 32'(queue_count), 32'd0);
      ctrl_state = 5'b00000; cyc(); cyc();
      chk("mis perr sticky", 32'(proto_err), 32'd1);

      // Fresh reset, then accept with an empty queue.
      RESET = 1'b0; #1;
      chk("rst2 perr", 32'(proto_err), 32'd0);
      RESET = 1'b1;
      cyc();
      ctrl_state = 5'b10000; cyc();
      chk("empty perr", 32'(proto_err), 32'd1);
      chk("empty count", 32'(queue_count), 32'd0);
      ctrl_state = 5'b00000; cyc();

      // Push and accept in the same cycle with one entry queued.
      host_valid = 1'b1; host_we = 1'b1; host_addr = A_D; cyc();
      chk("D count", 32'(queue_count), 32'd1);
      host_we = 1'b0; host_addr = A_E; ctrl_state = 5'b11000; cyc();
      host_valid = 1'b0;
      chk("pp count", 32'(queue_count), 32'd1);
      chk("pp rd_en", 32'(rd_enable), 32'd1);
      chk("pp addr", 32'(req_addr), 32'(A_E));

      // Reset in the middle of a write.
      ctrl_state = 5'b11001; cyc();
      RESET = 1'b0; #1;
      chk_reset_vals("midrst");
      cyc();
      RESET = 1'b1;
      cyc();

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/sdram_request_scheduler.md
Name: sdram_request_scheduler

Overview:
Upstream stage of the SDRAM command FSM. It accepts host read/write requests over a valid/ready handshake and buffers them in a 2-entry queue. It drives the FSM's rd_enable/wr_enable/refresh_cnt inputs and watches the FSM's 5-bit state output to detect request acceptance, refresh issue and operation completion.

Parameters:
ADDR_WIDTH, 22, width of host request address
REFRESH_WIDTH, 10, width of refresh_cnt
REFRESH_THRESHOLD, 519, refresh_cnt value at/above which refresh_urgent asserts

Ports:
CLK  input  1  clock
RESET  input  1  asynchronous, active-low reset
host_valid  input  1  host request valid
host_ready  output  1  scheduler can accept a request
host_we  input  1  1 = write, 0 = read
host_addr  input  ADDR_WIDTH  request address
ctrl_state  input  5  state output of SDRAM command FSM
rd_enable  output  1  read request to FSM
wr_enable  output  1  write request to FSM
req_addr  output  ADDR_WIDTH  address of queue head
refresh_cnt  output  REFRESH_WIDTH  cycles since last refresh
refresh_urgent  output  1  refresh_cnt >= REFRESH_THRESHOLD
op_done  output  1  one-cycle pulse on read/write completion
op_done_we  output  1  type of completed op, valid with op_done
queue_count  output  2  occupied entries (0..2)
proto_err  output  1  sticky: FSM accepted an op type different from the head

Behaviour:
- FSM state codes: IDLE=00000, REF_START=00001, INIT_LAST=01111, WR_START=11000, RD_START=10000. Read/write path = bit4 set.
- prev_state register samples ctrl_state every CLK; reset value INIT (01000). Events are edge-detected from prev_state → ctrl_state. FSM state can hold for many CLKs (clock-enabled), so each event fires exactly once per transition.
- Reset (async, RESET=0): queue empty, queue_count=0, host_ready=1, rd_enable=wr_enable=0, req_addr=0, refresh_cnt=0, refresh_urgent=0, op_done=0, op_done_we=0, proto_err=0.
- Queue: 2-entry FIFO of {we, addr}.
  - Push when host_valid & host_ready. host_ready = (queue_count != 2), registered-free and combinational from count.
  - Head visible the cycle after push (1-cycle latency).
- Request drive:
  - wr_enable = head_valid & head_we.
  - rd_enable = head_valid & ~head_we.
  - req_addr = head addr, or 0 when empty.
  - These are held stable until acceptance.
- Acceptance:
  - prev_state==IDLE and ctrl_state==WR_START or RD_START → pop head that cycle.
  - If the accepted type mismatches head_we, or the queue is empty, set proto_err (sticky until reset) and still pop if non-empty.
- Simultaneous push and pop: count unchanged; ordering preserved. Push is blocked when full even if a pop occurs the same cycle (host_ready depends on count only).
- Refresh counter:
  - Increments by 1 every CLK and saturates at 2^REFRESH_WIDTH-1.
  - Clears to 0 on prev_state==IDLE & ctrl_state==REF_START, or on prev_state==INIT_LAST & ctrl_state==IDLE (end of init sequence). Clear wins over increment.
  - refresh_urgent is combinational compare.
- Completion: prev_state bit4=1 and ctrl_state==IDLE → op_done=1 for one CLK, op_done_we=prev_state[3]. Otherwise op_done=0, and op_done_we holds its last value.
- Mid-operation reset: everything returns to reset values. Pending requests are dropped; host must re-issue.

Test Plan:
- Reset, then hold ctrl_state=01000 for 50 cycles → host_ready=1, enables 0, refresh_cnt=50. Step ctrl_state 01111→00000 → refresh_cnt=0 next cycle.
- Push write addr 0x12345 → wr_enable=1, req_addr=0x12345 next cycle. Drive ctrl_state 00000→11000 → queue_count=0, wr_enable=0. Drive 11011→00000 → op_done=1, op_done_we=1 for one cycle.
- Push read A then write B with ctrl_state idle → queue_count=2, host_ready=0, rd_enable=1 with addr A. Accept read (00000→10000) → head becomes B, wr_enable=1, host_ready=1.
- Hold IDLE for 519 cycles → refresh_urgent=1 at refresh_cnt=519. Drive 00000→00001 → refresh_cnt=0, refresh_urgent=0. Hold 1100 cycles without refresh → refresh_cnt saturates at 1023.
- Queue holds read, FSM shows 00000→11000 → proto_err=1 and stays 1; entry popped. Empty queue plus 00000→10000 → proto_err=1, count stays 0.
- With 1 entry queued, push and accept in the same cycle → queue_count stays 1, new entry at head. Assert RESET mid-write (state 11001) → all outputs return to reset values immediately.
